// File: rtl/dl_mem_arbiter_if.sv
// Bus bundle between the HPS download/CPU side and the memory arbiter.
// slave  : arbiter view (download + CPU request inputs, memory/status outputs)
// master : host/bench view (drives requests, observes memory/status)
interface dl_mem_arbiter_if;
    localparam int unsigned IO_ADDR_W  = 25;
    localparam int unsigned MEM_ADDR_W = 17;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned SEL_W      = 2;

    logic                  ioctl_download;
    logic                  ioctl_wr;
    logic [IO_ADDR_W-1:0]  ioctl_addr;
    logic [DATA_W-1:0]     ioctl_dout;
    logic [DATA_W-1:0]     ioctl_index;

    logic                  cpu_req;
    logic                  cpu_we;
    logic [MEM_ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0]     cpu_din;
    logic [SEL_W-1:0]      cpu_sel;
    logic                  cpu_ack;
    logic                  cpu_hold;

    logic                  mem_en;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_din;
    logic [SEL_W-1:0]      mem_sel;

    logic                  dl_done;
    logic [MEM_ADDR_W-1:0] dl_len;
    logic                  fifo_overflow;
    logic                  addr_err;

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  cpu_req, cpu_we, cpu_addr, cpu_din, cpu_sel,
        output cpu_ack, cpu_hold,
        output mem_en, mem_we, mem_addr, mem_din, mem_sel,
        output dl_done, dl_len, fifo_overflow, addr_err
    );

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output cpu_req, cpu_we, cpu_addr, cpu_din, cpu_sel,
        input  cpu_ack, cpu_hold,
        input  mem_en, mem_we, mem_addr, mem_din, mem_sel,
        input  dl_done, dl_len, fifo_overflow, addr_err
    );
endinterface

// File: rtl/dl_mem_arbiter.sv
// Arbitrates a single memory port between HPS download bytes (buffered in a
// small FIFO, always given priority) and single-beat CPU accesses.
// Ports: clk_sys - core clock; reset - synchronous active-high reset;
//        bus     - dl_mem_arbiter_if.slave (download in, CPU req/ack/hold,
//                  memory port, dl_done/dl_len and sticky error flags).
module dl_mem_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    dl_mem_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW    = 17;

    typedef struct packed {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } entry_t;

    typedef enum logic [2:0] {IDLE, CPU_ACC, CPU_ACK, DL, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    entry_t        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [AW-1:0] dl_len_q, dl_len_d, len_cand;
    logic          ovf_q, ovf_d, aerr_q, aerr_d;
    logic          dl_valid_q, dl_valid_d;

    logic          idx_ok, wr_hit, addr_lo_ok, push_req, push, pop;
    logic          fifo_empty, fifo_full;
    logic [1:0]    idx_sel;
    entry_t        head;

    logic          cpu_ack_c, cpu_hold_c, mem_en_c, mem_we_c, dl_done_c;
    logic [AW-1:0] mem_addr_c;
    logic [7:0]    mem_din_c;
    logic [1:0]    mem_sel_c;

    // Download index to target memory decode.
    always_comb begin
        idx_ok  = 1'b1;
        idx_sel = 2'd0;
        case (bus.ioctl_index)
            8'd0, 8'd1: idx_sel = 2'd0;
            8'd3:       idx_sel = 2'd1;
            8'd4:       idx_sel = 2'd2;
            default:    idx_ok  = 1'b0;
        endcase
    end

    assign wr_hit     = bus.ioctl_download & bus.ioctl_wr & idx_ok;
    assign addr_lo_ok = (bus.ioctl_addr[24:17] == 8'd0);
    assign push_req   = wr_hit & addr_lo_ok;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = ((state_q == DL) || (state_q == DRAIN)) && !fifo_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = push_req & (!fifo_full | pop);
    assign head       = fifo_mem[rd_ptr_q];
    assign len_cand   = head.addr + 17'd1;

    // FIFO storage (no reset needed, validity is tracked by count_q).
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{sel: idx_sel, addr: bus.ioctl_addr[16:0], data: bus.ioctl_dout};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State, length and sticky flag registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            dl_len_q   <= '0;
            ovf_q      <= 1'b0;
            aerr_q     <= 1'b0;
            dl_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_len_q   <= dl_len_d;
            ovf_q      <= ovf_d;
            aerr_q     <= aerr_d;
            dl_valid_q <= dl_valid_d;
        end
    end

    // Next state and memory-port/handshake outputs.
    always_comb begin
        state_d    = state_q;
        dl_len_d   = dl_len_q;
        ovf_d      = ovf_q | (push_req & fifo_full & !pop);
        aerr_d     = aerr_q | (wr_hit & !addr_lo_ok);
        dl_valid_d = dl_valid_q | (bus.ioctl_download & idx_ok);
        cpu_ack_c  = 1'b0;
        cpu_hold_c = 1'b0;
        mem_en_c   = 1'b0;
        mem_we_c   = 1'b0;
        mem_addr_c = '0;
        mem_din_c  = '0;
        mem_sel_c  = '0;
        dl_done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                cpu_hold_c = bus.ioctl_download;
                if (bus.ioctl_download || !fifo_empty) begin
                    state_d  = DL;
                    dl_len_d = '0;
                    // Bytes already buffered belong to a valid-index download.
                    dl_valid_d = (bus.ioctl_download & idx_ok) | !fifo_empty;
                end else if (bus.cpu_req) begin
                    state_d = CPU_ACC;
                end
            end
            CPU_ACC: begin
                mem_en_c   = 1'b1;
                mem_we_c   = bus.cpu_we;
                mem_addr_c = bus.cpu_addr;
                mem_din_c  = bus.cpu_din;
                mem_sel_c  = bus.cpu_sel;
                state_d    = CPU_ACK;
            end
            CPU_ACK: begin
                cpu_ack_c = 1'b1;
                state_d   = IDLE;
            end
            DL: begin
                cpu_hold_c = 1'b1;
                if (!bus.ioctl_download) state_d = DRAIN;
            end
            DRAIN: begin
                cpu_hold_c = 1'b1;
                if (bus.ioctl_download) begin
                    state_d = DL;
                end else if ((count_q - CNT_W'(pop)) == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cpu_hold_c = 1'b1;
                // Downloads to an ignored index complete silently.
                dl_done_c  = dl_valid_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            mem_en_c   = 1'b1;
            mem_we_c   = 1'b1;
            mem_addr_c = head.addr;
            mem_din_c  = head.data;
            mem_sel_c  = head.sel;
            if (len_cand > dl_len_d) dl_len_d = len_cand;
        end

        // Hold every output low while reset is asserted.
        if (reset) begin
            cpu_ack_c  = 1'b0;
            cpu_hold_c = 1'b0;
            mem_en_c   = 1'b0;
            mem_we_c   = 1'b0;
            mem_addr_c = '0;
            mem_din_c  = '0;
            mem_sel_c  = '0;
            dl_done_c  = 1'b0;
        end
    end

    assign bus.cpu_ack       = cpu_ack_c;
    assign bus.cpu_hold      = cpu_hold_c;
    assign bus.mem_en        = mem_en_c;
    assign bus.mem_we        = mem_we_c;
    assign bus.mem_addr      = mem_addr_c;
    assign bus.mem_din       = mem_din_c;
    assign bus.mem_sel       = mem_sel_c;
    assign bus.dl_done       = dl_done_c;
    assign bus.dl_len        = dl_len_q;
    assign bus.fifo_overflow = ovf_q;
    assign bus.addr_err      = aerr_q;
endmodule

// File: doc/dl_mem_arbiter.md
DL_MEM_ARBITER -- requirements
Module: dl_mem_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, power of two: depth of the download write buffer.
REQ-002 SHALL have ports, one per line:
- clk_sys, in, 1: single core clock.
- reset, in, 1: synchronous, active-high.
- ioctl_download, in, 1: HPS download active.
- ioctl_wr, in, 1: download byte strobe.
- ioctl_addr, in, 25: download byte address.
- ioctl_dout, in, 8: download byte.
- ioctl_index, in, 8: download target index.
- cpu_req, in, 1: CPU access request, level, held until ack.
- cpu_we, in, 1: 1 = write, 0 = read.
- cpu_addr, in, 17: CPU address.
- cpu_din, in, 8: CPU write data.
- cpu_sel, in, 2: CPU target memory.
- cpu_ack, out, 1: one-cycle access complete.
- cpu_hold, out, 1: CPU must stall, download owns memory.
- mem_en, out, 1: memory port enable.
- mem_we, out, 1: memory write.
- mem_addr, out, 17: memory address.
- mem_din, out, 8: memory write data.
- mem_sel, out, 2: target memory (0 BIOS, 1 sprite, 2 music).
- dl_done, out, 1: one-cycle pulse when a download has fully landed.
- dl_len, out, 17: byte count of last download.
- fifo_overflow, out, 1: sticky error flag.
- addr_err, out, 1: sticky error flag.

Function
REQ-003 SHALL map ioctl_index 0 and 1 to sel 0, 3 to sel 1, and 4 to sel 2; any other index SHALL be ignored, with no push, no error and no dl_done.
REQ-004 SHALL push {sel, ioctl_addr[16:0], ioctl_dout} into the FIFO when ioctl_download, ioctl_wr, the index is valid and ioctl_addr[24:17] equals 0.
REQ-005 SHALL drop the byte and set addr_err when the REQ-004 conditions hold except that ioctl_addr[24:17] is nonzero.
REQ-006 SHALL, on a push while the FIFO is full with no pop in the same cycle, drop the byte and set fifo_overflow; a simultaneous push and pop on a full FIFO SHALL succeed.
REQ-007 SHALL implement states IDLE, CPU_ACC, CPU_ACK, DL, DRAIN and DONE.
REQ-008 SHALL have the following transitions out of IDLE:
- to DL when ioctl_download is high or the FIFO is non-empty;
- otherwise to CPU_ACC when cpu_req is high;
- download wins if both occur in the same cycle.
REQ-009 CPU_ACC SHALL assert mem_en for exactly one cycle, with mem_we=cpu_we, mem_addr=cpu_addr, mem_din=cpu_din and mem_sel=cpu_sel, then go to CPU_ACK.
REQ-010 CPU_ACK SHALL pulse cpu_ack for one cycle, then go to IDLE; a new cpu_req SHALL NOT be serviced in the CPU_ACK cycle.
REQ-011 In DL and DRAIN, SHALL pop one FIFO entry per cycle when non-empty and drive it with mem_en=1 and mem_we=1 in that same cycle.
REQ-012 DL SHALL go to DRAIN when ioctl_download is low.
REQ-013 DRAIN SHALL go to DONE when the FIFO is empty after that cycle's pop; DRAIN SHALL return to DL if ioctl_download rises again.
REQ-014 DONE SHALL pulse dl_done for one cycle, then go to IDLE.
REQ-015 dl_len SHALL equal (largest popped address of the current download) + 1; it SHALL be cleared on entry to DL from IDLE and updated as bytes are popped.
REQ-016 cpu_hold SHALL be 1 in DL, DRAIN and DONE, and SHALL be 1 combinationally in IDLE whenever ioctl_download is high; otherwise it SHALL be 0.
REQ-017 A cpu_req arriving during a download SHALL remain pending and SHALL be serviced after DONE→IDLE.
REQ-018 mem_en SHALL be 0 in IDLE, CPU_ACK and DONE.
REQ-019 mem_we SHALL never be 1 while mem_en is 0.
REQ-020 A CPU access already in CPU_ACC or CPU_ACK SHALL complete; download bytes arriving meanwhile SHALL buffer in the FIFO.

Reset
REQ-021 On reset SHALL go to IDLE, flush the FIFO, and drive every output to 0, including dl_len, fifo_overflow and addr_err.
REQ-022 Reset asserted mid-download SHALL abort it with no dl_done pulse.
REQ-023 After a mid-download reset, bytes SHALL be accepted again from the next valid ioctl_wr while ioctl_download is high.

Verification
REQ-024 SHALL cover: index 0, bytes 0xAA, 0xBB and 0xCC at addresses 0..2, one per 4 cycles, then ioctl_download low -> three mem writes with sel 0 and matching address/data; one dl_done pulse; dl_len = 3; no cpu_ack.
REQ-025 SHALL cover: cpu_req read of addr 0x00100, sel 1, from IDLE -> mem_en=1 and mem_we=0 for one cycle, then cpu_ack one cycle later; cpu_hold = 0 throughout.
REQ-026 SHALL cover: cpu_req and a download start in the same cycle -> download serviced first; cpu_hold = 1; cpu_ack only after dl_done.
REQ-027 SHALL cover: FIFO_DEPTH+2 ioctl_wr pushes on consecutive cycles, starting while in CPU_ACC -> pushes buffer, drain completes, fifo_overflow stays 0; forcing full with no pop -> fifo_overflow = 1 and stays set until reset.
REQ-028 SHALL cover: index 4 with ioctl_addr = 0x20000 -> no memory write; addr_err = 1. Index 2 -> ignored with no flags.
REQ-029 SHALL cover: reset after 2 of 5 bytes -> all outputs 0, no dl_done; a fresh download afterwards completes normally with dl_len correct.
